// File: rtl/cla_subtractor_serial.sv
// Slice-serial subtractor: diff = a - b - bin, one 4-bit carry look-ahead slice per clock, LSB slice first.
// The borrow between slices is registered, so an operation takes NSLICE cycles in RUN plus one in DONE.
module cla_subtractor_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = $clog2(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow;
   logic [4:0]       slice_sum;

   // Returns {carry_out, sum[3:0]} of x + y + cin using flat look-ahead carries.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      p    = x ^ y;
      g    = x & y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   always_comb begin
      slice_sum = cla4(a_q[{count, 2'b00} +: 4], ~b_q[{count, 2'b00} +: 4], ~borrow);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         borrow <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  borrow <= bin;
                  count  <= '0;
                  diff   <= '0;
                  bout   <= 1'b0;
                  ovf    <= 1'b0;
                  zero   <= 1'b0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               diff[{count, 2'b00} +: 4] <= slice_sum[3:0];
               borrow <= ~slice_sum[4];
               count  <= count + 1'b1;
               if (count == LAST) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               // Overflow: operand signs differ and the result sign disagrees with the minuend.
               done  <= 1'b1;
               bout  <= borrow;
               ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
               zero  <= (diff == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cla_subtractor_serial.md
Name: cla_subtractor_serial

Overview:
- Multi-cycle subtractor: computes diff = a - b - bin on WIDTH-bit operands, one 4-bit slice per clock, LSB slice first.
- Each slice uses 4-bit carry look-ahead logic on a + ~b + c, with c = ~borrow. Slice borrow-out is registered and chained to the next slice.
- Sits beside the combinational CLA adder as the area-lean subtract/compare path for ALU and datapath control.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 8.
- NSLICE, WIDTH/4, derived slice count; not overridable.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when results become valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff a < b + bin, unsigned.
- ovf  output  1  signed two's-complement overflow of the subtraction.
- zero  output  1  diff == 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0, zero=0, state=IDLE, slice counter=0.
- The rst edge overrides everything, including mid-RUN. A partial result is discarded and never signalled.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b and bin, set the borrow register to bin, clear the counter and diff, then go to RUN. Otherwise hold all outputs.
- RUN, slice k = counter:
  - s = a[4k+3:4k] + ~b[4k+3:4k] + ~borrow, using 4-bit CLA (p = a^~b, g = a&~b).
  - diff[4k+3:4k] <= s[3:0].
  - borrow <= ~cout.
  - counter <= counter+1.
- After slice NSLICE-1 is processed, go to DONE.
- busy=1 exactly in RUN, for NSLICE cycles.
- DONE, one cycle:
  - done=1; bout = final borrow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using latched operands.
  - zero = (diff == 0).
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge 0, done high during the cycle after edge NSLICE+1. For WIDTH=16, done is seen 5 cycles after start.
- diff, bout, ovf and zero hold their values after DONE until the next accepted start. Upon that start, diff and the flags clear.
- start while busy or in DONE is ignored and not queued; the operands are not re-sampled.
- Changes on a, b or bin after start do not affect the result.
- Width rule: all arithmetic is modulo 2^WIDTH. There is no saturation.
- Boundary case a=b, bin=1: diff is all ones, bout=1, zero=0.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0034, bin=0, start 1 cycle -> busy high 4 cycles, then done pulse; diff=0x1200, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; also a=0x5555, b=0x5555, bin=1 -> diff=0xFFFF, bout=1, zero=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0; also a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
- a=0x0010, b=0x000F, bin=1 -> diff=0x0000, zero=1, bout=0; this checks the borrow chain across the slice 0→1 boundary.
- Start a=0x00FF, b=0x0001. In RUN cycle 2, pulse start with a=0xFFFF and change the a input. -> Second start is ignored; diff=0x00FE after one done pulse; no second done follows.
- Start an operation, assert rst for 1 cycle in RUN cycle 2 -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start of a=0x0003, b=0x0002 then gives diff=0x0001 with normal 5-cycle latency.
